// File: rtl/curve_uop_engine_pkg.sv
// Shared microcode definitions for the curve point-operation uop engine:
// field layout, one-hot opcodes, operand/destination selects and exec codes.
package curve_uop_engine_pkg;

    localparam int OP_MSB   = 19;
    localparam int OP_LSB   = 14;
    localparam int SA_MSB   = 13;
    localparam int SA_LSB   = 10;
    localparam int SB_MSB   = 9;
    localparam int SB_LSB   = 6;
    localparam int DST_MSB  = 5;
    localparam int DST_LSB  = 3;
    localparam int EXEC_MSB = 2;
    localparam int EXEC_LSB = 0;

    localparam int OP_W   = 6;
    localparam int SRC_W  = 4;
    localparam int DST_W  = 3;
    localparam int EXEC_W = 3;

    localparam logic [OP_W-1:0] OPCODE_CMP = 6'b000001;
    localparam logic [OP_W-1:0] OPCODE_MOV = 6'b000010;
    localparam logic [OP_W-1:0] OPCODE_ADD = 6'b000100;
    localparam logic [OP_W-1:0] OPCODE_SUB = 6'b001000;
    localparam logic [OP_W-1:0] OPCODE_MUL = 6'b010000;
    localparam logic [OP_W-1:0] OPCODE_RDY = 6'b100000;

    localparam logic [SRC_W-1:0] UOP_SRC_ZERO = 4'd0;
    localparam logic [SRC_W-1:0] UOP_SRC_ONE  = 4'd1;
    localparam logic [SRC_W-1:0] UOP_SRC_G_X  = 4'd2;
    localparam logic [SRC_W-1:0] UOP_SRC_G_Y  = 4'd3;
    localparam logic [SRC_W-1:0] UOP_SRC_H_X  = 4'd4;
    localparam logic [SRC_W-1:0] UOP_SRC_H_Y  = 4'd5;
    localparam logic [SRC_W-1:0] UOP_SRC_PZ   = 4'd6;
    localparam logic [SRC_W-1:0] UOP_SRC_T1   = 4'd7;
    localparam logic [SRC_W-1:0] UOP_SRC_T2   = 4'd8;

    localparam logic [DST_W-1:0] UOP_DST_RX = 3'd0;
    localparam logic [DST_W-1:0] UOP_DST_RY = 3'd1;
    localparam logic [DST_W-1:0] UOP_DST_RZ = 3'd2;
    localparam logic [DST_W-1:0] UOP_DST_T1 = 3'd3;
    localparam logic [DST_W-1:0] UOP_DST_T2 = 3'd4;
    localparam logic [DST_W-1:0] UOP_DST_T3 = 3'd5;

    localparam logic [EXEC_W-1:0] UOP_EXEC_ALWAYS     = 3'd0;
    localparam logic [EXEC_W-1:0] UOP_EXEC_PZT1T2_0XX = 3'd1;
    localparam logic [EXEC_W-1:0] UOP_EXEC_PZT1T2_100 = 3'd2;
    localparam logic [EXEC_W-1:0] UOP_EXEC_PZT1T2_101 = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC
    } state_t;

    function automatic logic is_onehot(input logic [OP_W-1:0] v);
        return (v != '0) && ((v & (v - 6'd1)) == '0);
    endfunction

endpackage

// File: rtl/curve_uop_engine_cond.sv
// Exec-condition evaluator: decides whether a uop runs given the stored
// compare flags {pz_zero, t1_zero, t2_zero}.
module curve_uop_cond
    import curve_uop_engine_pkg::*;
(
    input  logic [EXEC_W-1:0] exec,
    input  logic [2:0]        flags,
    output logic              exec_ok
);

    // Exec names encode non-zero-ness of PZ,T1,T2 while flags record
    // zero results, so the fixed patterns appear bit-inverted here.
    always_comb begin
        exec_ok = 1'b0;
        case (exec)
            UOP_EXEC_ALWAYS:     exec_ok = 1'b1;
            UOP_EXEC_PZT1T2_0XX: exec_ok = flags[2];
            UOP_EXEC_PZT1T2_100: exec_ok = (flags == 3'b011);
            UOP_EXEC_PZT1T2_101: exec_ok = (flags == 3'b010);
            default:             exec_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/curve_uop_engine.sv
// Microcode sequencer: fetches uops from the point-operation ROM, evaluates
// their exec condition and issues them to the modular-arithmetic datapath.
module curve_uop_engine
    import curve_uop_engine_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int UOP_W  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    output logic              rdy,
    output logic              err,
    output logic [ADDR_W-1:0] uop_addr,
    input  logic [UOP_W-1:0]  uop_data,
    output logic              dp_ena,
    output logic [OP_W-1:0]   dp_opcode,
    output logic [SRC_W-1:0]  dp_src_a,
    output logic [SRC_W-1:0]  dp_src_b,
    output logic [DST_W-1:0]  dp_dst,
    input  logic              dp_rdy,
    input  logic              dp_cmp_eq
);

    state_t             state;
    logic [2:0]         flags;
    logic [OP_W-1:0]    f_op;
    logic [SRC_W-1:0]   f_sa;
    logic [SRC_W-1:0]   f_sb;
    logic [DST_W-1:0]   f_dst;
    logic [EXEC_W-1:0]  f_exec;
    logic               exec_ok;
    logic               addr_last;

    assign f_op      = uop_data[OP_MSB:OP_LSB];
    assign f_sa      = uop_data[SA_MSB:SA_LSB];
    assign f_sb      = uop_data[SB_MSB:SB_LSB];
    assign f_dst     = uop_data[DST_MSB:DST_LSB];
    assign f_exec    = uop_data[EXEC_MSB:EXEC_LSB];
    assign addr_last = (uop_addr == '1);

    curve_uop_cond u_cond (
        .exec    (f_exec),
        .flags   (flags),
        .exec_ok (exec_ok)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rdy       <= 1'b1;
            err       <= 1'b0;
            uop_addr  <= '0;
            dp_ena    <= 1'b0;
            dp_opcode <= '0;
            dp_src_a  <= '0;
            dp_src_b  <= '0;
            dp_dst    <= '0;
            flags     <= '0;
        end else begin
            dp_ena <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ena) begin
                        uop_addr <= '0;
                        rdy      <= 1'b0;
                        err      <= 1'b0;
                        flags    <= '0;
                        state    <= ST_FETCH;
                    end
                end
                ST_FETCH: state <= ST_DECODE;
                ST_DECODE: begin
                    if (!is_onehot(f_op)) begin
                        err   <= 1'b1;
                        rdy   <= 1'b1;
                        state <= ST_IDLE;
                    end else if (f_op == OPCODE_RDY) begin
                        rdy   <= 1'b1;
                        state <= ST_IDLE;
                    end else if (!exec_ok) begin
                        // Skipped uop: advance without touching the datapath.
                        if (addr_last) begin
                            err   <= 1'b1;
                            rdy   <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            uop_addr <= uop_addr + ADDR_W'(1);
                            state    <= ST_FETCH;
                        end
                    end else begin
                        dp_opcode <= f_op;
                        dp_src_a  <= f_sa;
                        dp_src_b  <= f_sb;
                        dp_dst    <= f_dst;
                        dp_ena    <= 1'b1;
                        state     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (dp_rdy) begin
                        if (dp_opcode == OPCODE_CMP) begin
                            flags <= {flags[1:0], dp_cmp_eq};
                        end
                        if (addr_last) begin
                            err   <= 1'b1;
                            rdy   <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            uop_addr <= uop_addr + ADDR_W'(1);
                            state    <= ST_FETCH;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_curve_uop_engine.sv
// Directed bench for curve_uop_engine with an addition-ROM model and a
// datapath model answering dp_rdy three cycles after each dp_ena.
module tb_curve_uop_engine;
    import curve_uop_engine_pkg::*;

    localparam int ADDR_W = 6;
    localparam int UOP_W  = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic              ena;
    logic              rdy;
    logic              err;
    logic [ADDR_W-1:0] uop_addr;
    logic [UOP_W-1:0]  uop_data;
    logic              dp_ena;
    logic [5:0]        dp_opcode;
    logic [3:0]        dp_src_a;
    logic [3:0]        dp_src_b;
    logic [2:0]        dp_dst;
    logic              dp_rdy;
    logic              model_rdy;
    logic              stray_rdy;
    logic              dp_cmp_eq;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [UOP_W-1:0] rom [64];
    logic [UOP_W-1:0] rom_pend;
    logic             cmp_res [3];
    int               cmp_idx;
    int               log_addr [$];
    logic [5:0]       log_op [$];
    logic [3:0]       log_sa [$];
    logic [2:0]       log_dst [$];

    assign dp_rdy = model_rdy | stray_rdy;

    always #5 clk = ~clk;

    curve_uop_engine #(.ADDR_W(ADDR_W), .UOP_W(UOP_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .rdy       (rdy),
        .err       (err),
        .uop_addr  (uop_addr),
        .uop_data  (uop_data),
        .dp_ena    (dp_ena),
        .dp_opcode (dp_opcode),
        .dp_src_a  (dp_src_a),
        .dp_src_b  (dp_src_b),
        .dp_dst    (dp_dst),
        .dp_rdy    (dp_rdy),
        .dp_cmp_eq (dp_cmp_eq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [UOP_W-1:0] mk(input logic [5:0] op, input logic [3:0] a,
                                            input logic [3:0] b, input logic [2:0] d,
                                            input logic [2:0] ex);
        return {op, a, b, d, ex};
    endfunction

    task automatic load_rom();
        logic [5:0] op;
        for (int i = 0; i < 64; i++) rom[i] = mk(OPCODE_RDY, 4'd0, 4'd0, 3'd0, 3'd0);
        for (int i = 0; i < 20; i++) begin
            case (i % 4)
                0:       op = OPCODE_MOV;
                1:       op = OPCODE_ADD;
                2:       op = OPCODE_SUB;
                default: op = OPCODE_MUL;
            endcase
            rom[i] = mk(op, 4'(i % 16), 4'((i + 3) % 16), 3'(i % 6), UOP_EXEC_ALWAYS);
        end
        rom[20] = mk(OPCODE_CMP, UOP_SRC_PZ, UOP_SRC_ZERO, UOP_DST_T3, UOP_EXEC_ALWAYS);
        rom[21] = mk(OPCODE_CMP, UOP_SRC_T1, UOP_SRC_ZERO, UOP_DST_T3, UOP_EXEC_ALWAYS);
        rom[22] = mk(OPCODE_CMP, UOP_SRC_T2, UOP_SRC_ZERO, UOP_DST_T3, UOP_EXEC_ALWAYS);
        rom[23] = mk(OPCODE_MUL, UOP_SRC_T1, UOP_SRC_T2, UOP_DST_RZ, UOP_EXEC_ALWAYS);
        rom[24] = mk(OPCODE_MOV, UOP_SRC_G_X, UOP_SRC_ZERO, UOP_DST_RX, UOP_EXEC_PZT1T2_0XX);
        rom[25] = mk(OPCODE_MOV, UOP_SRC_G_Y, UOP_SRC_ZERO, UOP_DST_RY, UOP_EXEC_PZT1T2_0XX);
        rom[26] = mk(OPCODE_MOV, UOP_SRC_ONE, UOP_SRC_ZERO, UOP_DST_RZ, UOP_EXEC_PZT1T2_0XX);
        rom[27] = mk(OPCODE_MOV, UOP_SRC_H_X, UOP_SRC_ZERO, UOP_DST_RX, UOP_EXEC_PZT1T2_100);
        rom[28] = mk(OPCODE_MOV, UOP_SRC_H_Y, UOP_SRC_ZERO, UOP_DST_RY, UOP_EXEC_PZT1T2_100);
        rom[29] = mk(OPCODE_MOV, UOP_SRC_ONE, UOP_SRC_ZERO, UOP_DST_RZ, UOP_EXEC_PZT1T2_100);
        rom[30] = mk(OPCODE_MOV, UOP_SRC_ONE, UOP_SRC_ZERO, UOP_DST_RX, UOP_EXEC_PZT1T2_101);
        rom[31] = mk(OPCODE_MOV, UOP_SRC_ONE, UOP_SRC_ZERO, UOP_DST_RY, UOP_EXEC_PZT1T2_101);
        rom[32] = mk(OPCODE_MOV, UOP_SRC_ZERO, UOP_SRC_ZERO, UOP_DST_RZ, UOP_EXEC_PZT1T2_101);
        // RDY with a reserved exec code: the exec field must be ignored.
        rom[33] = mk(OPCODE_RDY, 4'd0, 4'd0, 3'd0, 3'd5);
    endtask

    // Registered ROM: data for an address appears one clock after it is driven.
    initial begin
        uop_data = '0;
        rom_pend = '0;
        forever begin
            @(negedge clk);
            uop_data = rom_pend;
            rom_pend = rom[uop_addr];
        end
    end

    // Datapath model: logs each issue, answers three cycles later.
    initial begin
        int cnt;
        logic [16:0] issued;
        model_rdy = 1'b0;
        dp_cmp_eq = 1'b1;
        cnt = 0;
        issued = '0;
        forever begin
            @(negedge clk);
            model_rdy = 1'b0;
            dp_cmp_eq = 1'b1;
            if (rst) begin
                cnt = 0;
            end else if (dp_ena) begin
                cnt = 3;
                log_addr.push_back(int'(uop_addr));
                log_op.push_back(dp_opcode);
                log_sa.push_back(dp_src_a);
                log_dst.push_back(dp_dst);
                issued = {dp_opcode, dp_src_a, dp_src_b, dp_dst};
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    model_rdy = 1'b1;
                    check("dp_fields_stable", {15'd0, dp_opcode, dp_src_a, dp_src_b, dp_dst},
                          {15'd0, issued});
                    if (dp_opcode == OPCODE_CMP && cmp_idx < 3) begin
                        dp_cmp_eq = cmp_res[cmp_idx];
                        cmp_idx++;
                    end
                end
            end
        end
    end

    task automatic run(input logic c0, input logic c1, input logic c2, input bit poke,
                       output int cycles, output logic err_at_start);
        bit poked;
        log_addr.delete();
        log_op.delete();
        log_sa.delete();
        log_dst.delete();
        cmp_res = '{c0, c1, c2};
        cmp_idx = 0;
        poked = 0;
        @(negedge clk);
        ena = 1'b1;
        @(negedge clk);
        ena = 1'b0;
        err_at_start = err;
        cycles = 0;
        while (!rdy && cycles < 2000) begin
            @(negedge clk);
            cycles++;
            if (poke) begin
                ena = !poked && dp_ena;
                if (ena) poked = 1;
            end
        end
        ena = 1'b0;
        check("run_timeout", {31'd0, cycles < 2000}, 32'd1);
    endtask

    task automatic check_run(input string tag, input int cycles, input int exp_n,
                             input int exp_cycles, input logic [2:0] exp_flags, input int base,
                             input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                             input logic [2:0] d0, input logic [2:0] d1, input logic [2:0] d2);
        logic [3:0] exp_s [3];
        logic [2:0] exp_d [3];
        exp_s = '{s0, s1, s2};
        exp_d = '{d0, d1, d2};
        $display("scenario %s", tag);
        check("pulse_count", log_addr.size(), exp_n);
        check("run_cycles", cycles, exp_cycles);
        check("rdy_end", {31'd0, rdy}, 32'd1);
        check("err_end", {31'd0, err}, 32'd0);
        check("end_addr", {26'd0, uop_addr}, 32'd33);
        check("flags_end", {29'd0, dut.flags}, {29'd0, exp_flags});
        for (int i = 0; i < 24 && i < log_addr.size(); i++) check("issue_addr", log_addr[i], i);
        if (exp_n == 27 && log_addr.size() == 27) begin
            for (int j = 0; j < 3; j++) begin
                check("tail_addr", log_addr[24 + j], base + j);
                check("tail_op", {26'd0, log_op[24 + j]}, {26'd0, OPCODE_MOV});
                check("tail_src", {28'd0, log_sa[24 + j]}, {28'd0, exp_s[j]});
                check("tail_dst", {29'd0, log_dst[24 + j]}, {29'd0, exp_d[j]});
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   cyc;
        logic e0;
        rst = 1'b1;
        ena = 1'b0;
        stray_rdy = 1'b0;
        load_rom();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_rdy", {31'd0, rdy}, 32'd1);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_addr", {26'd0, uop_addr}, 32'd0);
        check("rst_dp_ena", {31'd0, dp_ena}, 32'd0);
        check("rst_dp_fields", {15'd0, dp_opcode, dp_src_a, dp_src_b, dp_dst}, 32'd0);
        check("rst_flags", {29'd0, dut.flags}, 32'd0);

        run(1'b0, 1'b0, 1'b0, 1'b0, cyc, e0);
        check_run("generic", cyc, 24, 164, 3'b000, 0, 4'd0, 4'd0, 4'd0, 3'd0, 3'd0, 3'd0);
        run(1'b1, 1'b0, 1'b0, 1'b0, cyc, e0);
        check_run("pz_zero", cyc, 27, 176, 3'b100, 24, UOP_SRC_G_X, UOP_SRC_G_Y, UOP_SRC_ONE,
                  UOP_DST_RX, UOP_DST_RY, UOP_DST_RZ);
        run(1'b0, 1'b1, 1'b1, 1'b0, cyc, e0);
        check_run("doubling", cyc, 27, 176, 3'b011, 27, UOP_SRC_H_X, UOP_SRC_H_Y, UOP_SRC_ONE,
                  UOP_DST_RX, UOP_DST_RY, UOP_DST_RZ);
        run(1'b0, 1'b1, 1'b0, 1'b0, cyc, e0);
        check_run("neg_g", cyc, 27, 176, 3'b010, 30, UOP_SRC_ONE, UOP_SRC_ONE, UOP_SRC_ZERO,
                  UOP_DST_RX, UOP_DST_RY, UOP_DST_RZ);

        rom[5] = mk(6'b000000, 4'd1, 4'd2, 3'd1, UOP_EXEC_ALWAYS);
        run(1'b0, 1'b0, 1'b0, 1'b0, cyc, e0);
        check("bad_op_err", {31'd0, err}, 32'd1);
        check("bad_op_rdy", {31'd0, rdy}, 32'd1);
        check("bad_op_cycles", cyc, 32);
        check("bad_op_addr", {26'd0, uop_addr}, 32'd5);
        check("bad_op_pulses", log_addr.size(), 5);
        repeat (10) @(negedge clk);
        check("bad_op_no_issue", log_addr.size(), 5);
        check("bad_op_err_held", {31'd0, err}, 32'd1);
        load_rom();
        run(1'b0, 1'b0, 1'b0, 1'b0, cyc, e0);
        check("err_cleared_by_ena", {31'd0, e0}, 32'd0);
        check_run("after_bad_op", cyc, 24, 164, 3'b000, 0, 4'd0, 4'd0, 4'd0, 3'd0, 3'd0, 3'd0);

        for (int i = 0; i < 64; i++) rom[i] = mk(OPCODE_MOV, 4'd1, 4'd0, 3'd0, 3'd4);
        run(1'b0, 1'b0, 1'b0, 1'b0, cyc, e0);
        check("ovf_err", {31'd0, err}, 32'd1);
        check("ovf_cycles", cyc, 128);
        check("ovf_addr", {26'd0, uop_addr}, 32'd63);
        check("ovf_pulses", log_addr.size(), 0);
        load_rom();

        run(1'b0, 1'b0, 1'b0, 1'b1, cyc, e0);
        check_run("ena_in_exec", cyc, 24, 164, 3'b000, 0, 4'd0, 4'd0, 4'd0, 3'd0, 3'd0, 3'd0);

        log_addr.delete();
        cmp_res = '{1'b0, 1'b0, 1'b0};
        cmp_idx = 0;
        @(negedge clk);
        ena = 1'b1;
        @(negedge clk);
        ena = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            #1;
            cyc++;
        end while (log_addr.size() < 2 && cyc < 100);
        check("rst_wait_issue", {31'd0, cyc < 100}, 32'd1);
        check("rst_pre_dp_ena", {31'd0, dp_ena}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_exec_rdy", {31'd0, rdy}, 32'd1);
        check("rst_exec_dp_ena", {31'd0, dp_ena}, 32'd0);
        check("rst_exec_addr", {26'd0, uop_addr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        stray_rdy = 1'b1;
        @(negedge clk);
        stray_rdy = 1'b0;
        repeat (6) @(negedge clk);
        check("stray_rdy_state", {31'd0, rdy}, 32'd1);
        check("stray_addr", {26'd0, uop_addr}, 32'd0);
        check("stray_flags", {29'd0, dut.flags}, 32'd0);
        check("stray_no_issue", log_addr.size(), 2);
        run(1'b0, 1'b0, 1'b0, 1'b0, cyc, e0);
        check_run("after_rst", cyc, 24, 164, 3'b000, 0, 4'd0, 4'd0, 4'd0, 3'd0, 3'd0, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
